kbd_move_scheduler: RTL
=======================

# kbd_move_scheduler

Frame-synchronous command scheduler between the PS/2 keyboard receiver and the VGA square renderer. It captures completed key strobes, keeps only W/A/S/D, and buffers them as 2-bit move commands in a small FIFO. It releases at most one command per video frame, and only during vertical blanking, so the square never moves mid-frame. Sits between the keyboard decoder outputs and the renderer's move-command input.

## Interface
- DEPTH, 4 — FIFO entries (power of two, ≥2)
- ACTIVE_START, 12'd37 — first active-video line; lines below it are the issue window
- KBD_W / KBD_A / KBD_S / KBD_D, 8'h57 / 8'h41 / 8'h53 / 8'h44 — accepted key codes
- clk  in  1  pixel clock (65 MHz)
- rst  in  1  reset, asynchronous, active-high
- kbd_signal  in  8  ASCII key code from the keyboard decoder
- kbd_ready  in  1  decoder strobe; a completed key is its falling edge
- v_counter  in  12  current line from the VGA timing generator, 0..805
- cmd_ready  in  1  renderer accepts a command this cycle
- cmd_valid  out  1  command offered
- cmd_dir  out  2  0 = up, 1 = down, 2 = left, 3 = right
- fifo_level  out  $clog2(DEPTH)+1  queued commands
- drop_count  out  8  saturating count of keys lost to a full FIFO

## Operation
- Key capture:
  - Register kbd_ready twice (r1, r2). A key event is r1 == 0 && r2 == 1.
  - On a key event, sample kbd_signal and map W→0, S→1, A→2, D→3.
  - Any other code is discarded. It is not counted as a drop.
- FIFO:
  - Push on a mapped key event when not full.
  - On a push attempt while full, discard the key and increment drop_count; it saturates at 255.
  - Pop on cmd_valid && cmd_ready.
  - Push and pop in the same cycle are both performed, including when full. The level is then unchanged.
  - Pointers wrap modulo DEPTH.
- Frame tick: v_counter == 0 while the registered previous v_counter != 0. This gives one pulse per frame.
- FSM:
  - WAIT: cmd_valid = 0. On a frame tick with the FIFO non-empty → OFFER.
  - OFFER: cmd_valid = 1, cmd_dir = FIFO head.
    - cmd_ready → pop and go to DONE.
    - Otherwise, when v_counter ≥ ACTIVE_START, drop cmd_valid and go to WAIT. The head stays queued and is retried next frame.
    - cmd_ready takes priority over window close in the same cycle.
  - DONE: cmd_valid = 0. On the next frame tick → OFFER if the FIFO is non-empty, else WAIT.
- Guarantee: at most one pop per frame. cmd_dir is stable while cmd_valid is high.
- Reset mid-operation clears the FIFO, pointers, drop_count and edge registers, and returns the FSM to WAIT. A command being offered is lost.

## Timing
- Reset values: cmd_valid = 0, cmd_dir = 0, fifo_level = 0, drop_count = 0, FSM = WAIT, r1 = r2 = 0, previous v_counter = 0.
- Key latency:
  - kbd_ready falls at cycle N; r1 samples 0 at edge N+1. The event is detected there and the push is registered at edge N+2.
  - fifo_level increments at N+2.
- Issue latency: cmd_valid is registered high on the clock edge after the frame-tick cycle.
- All outputs are registered. No combinational path from cmd_ready to cmd_valid.
- fifo_level updates on the edge after a push or pop.

## Structure
- Shared package `vga_kbd_pkg`:
  - key-code constants
  - dir encoding constants DIR_UP/DOWN/LEFT/RIGHT
  - FSM state localparams
  - VGA timing constants, so ACTIVE_START derives from V_FP + V_SYNCP + V_BP − 1
- One sub-module `sync_fifo` (parameterized width and depth, registered level). Instantiate it with width 2.
- Edge detection, key mapping and the FSM stay in the top.

## Test plan
- Single key: pulse kbd_ready with kbd_signal = 8'h44 mid-frame.
  - fifo_level = 1 at N+2.
  - At the next v_counter wrap to 0, cmd_valid rises with cmd_dir = 3.
  - With cmd_ready = 1: popped, fifo_level = 0, cmd_valid low until the next frame.
- Rate limit: enqueue W, A, S in one frame with cmd_ready held at 1.
  - Commands 0, 2, 1 are issued one per frame over three consecutive frames.
- Overflow: six D presses within one frame at DEPTH = 4.
  - fifo_level = 4, drop_count = 2.
  - Also enqueue 8'h51 ('Q'): no level change, drop_count unchanged.
- Stall and retry: enqueue S and hold cmd_ready = 0.
  - cmd_valid is high for lines 0..36 and drops at v_counter = 37.
  - fifo_level stays 1. The command is offered again next frame and popped when cmd_ready = 1.
- Simultaneous events: a full FIFO with pop and key-event push in the same cycle.
  - fifo_level stays 4, drop_count unchanged, and the new entry appears last in issue order.
- Async reset: assert rst during OFFER with 3 queued.
  - Same cycle: cmd_valid = 0, fifo_level = 0, drop_count = 0.
  - After release, no command issues until a new key arrives.

Source files
------------

// File: rtl/vga_kbd_pkg.sv
// Shared constants for the keyboard-to-VGA path: key codes, move directions,
// scheduler states and the vertical timing that places the issue window.
package vga_kbd_pkg;

    localparam logic [7:0] KBD_W_CODE = 8'h57;
    localparam logic [7:0] KBD_A_CODE = 8'h41;
    localparam logic [7:0] KBD_S_CODE = 8'h53;
    localparam logic [7:0] KBD_D_CODE = 8'h44;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    // 1024x768@60 vertical timing; blanking lines precede active video here
    localparam int V_FP    = 3;
    localparam int V_SYNCP = 6;
    localparam int V_BP    = 29;
    localparam logic [11:0] ACTIVE_START_LINE = 12'(V_FP + V_SYNCP + V_BP - 1);

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_OFFER = 2'd1,
        ST_DONE  = 2'd2
    } sched_state_t;

endpackage

// File: rtl/kbd_move_scheduler_if.sv
// Bundle of keyboard, video-timing and move-command signals around the scheduler.
interface kbd_move_scheduler_if #(
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [7:0]    kbd_signal;
    logic          kbd_ready;
    logic [11:0]   v_counter;
    logic          cmd_ready;
    logic          cmd_valid;
    logic [1:0]    cmd_dir;
    logic [LW-1:0] fifo_level;
    logic [7:0]    drop_count;

    modport master (
        output kbd_signal, kbd_ready, v_counter, cmd_ready,
        input  cmd_valid, cmd_dir, fifo_level, drop_count
    );

    modport slave (
        input  kbd_signal, kbd_ready, v_counter, cmd_ready,
        output cmd_valid, cmd_dir, fifo_level, drop_count
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [LW-1:0]    level_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_reg == LW'(DEPTH));
    assign empty   = (level_reg == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    // Head is read straight from the array so it is usable the cycle level goes non-zero
    assign rdata = mem[rd_ptr_reg];
    assign level = level_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (do_push && !do_pop) begin
                level_reg <= level_reg + 1'b1;
            end else if (do_pop && !do_push) begin
                level_reg <= level_reg - 1'b1;
            end
        end
    end

endmodule

// File: rtl/kbd_move_scheduler.sv
// Turns W/A/S/D key strobes into queued move commands and releases at most one
// per video frame, only inside vertical blanking.
module kbd_move_scheduler
    import vga_kbd_pkg::*;
#(
    parameter int          DEPTH        = 4,
    parameter logic [11:0] ACTIVE_START = ACTIVE_START_LINE,
    parameter logic [7:0]  KBD_W        = KBD_W_CODE,
    parameter logic [7:0]  KBD_A        = KBD_A_CODE,
    parameter logic [7:0]  KBD_S        = KBD_S_CODE,
    parameter logic [7:0]  KBD_D        = KBD_D_CODE
) (
    input logic                 clk,
    input logic                 rst,
    kbd_move_scheduler_if.slave bus
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          r1_reg;
    logic          r2_reg;
    logic [11:0]   v_prev_reg;
    logic          key_event;
    logic          key_valid;
    logic [1:0]    key_dir;
    logic          frame_tick;
    logic          push_req;
    logic          pop_req;
    logic          fifo_full;
    logic          fifo_empty;
    logic [1:0]    fifo_head;
    logic [LW-1:0] fifo_level;
    sched_state_t  state_reg;
    logic          cmd_valid_reg;
    logic [1:0]    cmd_dir_reg;
    logic [7:0]    drop_count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_reg     <= 1'b0;
            r2_reg     <= 1'b0;
            v_prev_reg <= '0;
        end else begin
            r1_reg     <= bus.kbd_ready;
            r2_reg     <= r1_reg;
            v_prev_reg <= bus.v_counter;
        end
    end

    // A completed key is the falling edge of the decoder strobe
    assign key_event  = ~r1_reg & r2_reg;
    assign frame_tick = (bus.v_counter == 12'd0) && (v_prev_reg != 12'd0);

    always_comb begin
        key_valid = 1'b0;
        key_dir   = DIR_UP;
        if (bus.kbd_signal == KBD_W) begin
            key_valid = 1'b1;
            key_dir   = DIR_UP;
        end else if (bus.kbd_signal == KBD_S) begin
            key_valid = 1'b1;
            key_dir   = DIR_DOWN;
        end else if (bus.kbd_signal == KBD_A) begin
            key_valid = 1'b1;
            key_dir   = DIR_LEFT;
        end else if (bus.kbd_signal == KBD_D) begin
            key_valid = 1'b1;
            key_dir   = DIR_RIGHT;
        end
    end

    assign push_req = key_event & key_valid;
    assign pop_req  = cmd_valid_reg & bus.cmd_ready;

    sync_fifo #(
        .WIDTH (2),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .wdata (key_dir),
        .pop   (pop_req),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // A key only counts as lost when no pop frees a slot in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count_reg <= 8'd0;
        end else if (push_req && fifo_full && !pop_req && drop_count_reg != 8'hFF) begin
            drop_count_reg <= drop_count_reg + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_WAIT;
            cmd_valid_reg <= 1'b0;
            cmd_dir_reg   <= DIR_UP;
        end else begin
            case (state_reg)
                ST_WAIT: begin
                    if (frame_tick && !fifo_empty) begin
                        state_reg     <= ST_OFFER;
                        cmd_valid_reg <= 1'b1;
                        cmd_dir_reg   <= fifo_head;
                    end
                end
                ST_OFFER: begin
                    // Acceptance wins over the window closing in the same cycle
                    if (bus.cmd_ready) begin
                        state_reg     <= ST_DONE;
                        cmd_valid_reg <= 1'b0;
                    end else if (bus.v_counter >= ACTIVE_START) begin
                        state_reg     <= ST_WAIT;
                        cmd_valid_reg <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (frame_tick) begin
                        if (!fifo_empty) begin
                            state_reg     <= ST_OFFER;
                            cmd_valid_reg <= 1'b1;
                            cmd_dir_reg   <= fifo_head;
                        end else begin
                            state_reg <= ST_WAIT;
                        end
                    end
                end
                default: begin
                    state_reg     <= ST_WAIT;
                    cmd_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_valid  = cmd_valid_reg;
    assign bus.cmd_dir    = cmd_dir_reg;
    assign bus.fifo_level = fifo_level;
    assign bus.drop_count = drop_count_reg;

endmodule
